// File: rtl/layer7_pkg.sv
// Shared types and constants for the layer-7 weight path: loader FSM states,
// weight memory geometry, and the beat lane selector.
package layer7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } wload_state_e;

  localparam int L7_WEIGHT_W  = 16;
  localparam int L7_ROW_LANES = 8;
  localparam int L7_ROWS      = 50;
  localparam int L7_WEIGHT_NUM = L7_ROW_LANES * L7_ROWS;
  localparam int L7_BUS_W     = 32;

  // Lane 0 is the low half of the beat, lane 1 the high half.
  function automatic logic [L7_WEIGHT_W-1:0] lane_select(input logic [L7_BUS_W-1:0] beat,
                                                         input logic               lane);
    logic [L7_WEIGHT_W-1:0] w_sel;
    if (lane) begin
      w_sel = beat[31:16];
    end else begin
      w_sel = beat[15:0];
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/counter_cnn.sv
// Clearable up-counter with enable; holds its value when neither clear nor enable is set.
module counter_cnn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer7_weight_loader.sv
// Unpacks 32-bit beats into one 16-bit weight write per cycle for the layer-7 weight memory.
// Optional running checksum output enabled by LAYER7_WLOAD_CKSUM_EN.
module layer7_weight_loader
  import layer7_pkg::*;
#(
  parameter int WEIGHT_NUM = L7_WEIGHT_NUM,
  parameter int BUS_W      = L7_BUS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  input  logic [BUS_W-1:0]       i_in_data,
  output logic                   o_in_ready,
  output logic                   o_write_weight_signal,
  output logic [L7_WEIGHT_W-1:0] o_write_weight_data,
  output logic [15:0]            o_write_weight_addr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_weights_loaded
`ifdef LAYER7_WLOAD_CKSUM_EN
  ,
  output logic [15:0]            o_cksum
`endif
);

  localparam int LANES = BUS_W / 16;

  wload_state_e r_state;
  wload_state_e w_state_nxt;

  logic [BUS_W-1:0]       r_buf;
  logic                   r_lane;
  logic                   r_busy;
  logic                   r_loaded;
  logic [15:0]            w_count;
  logic                   w_ready;
  logic                   w_start_acc;
  logic                   w_hs;
  logic                   w_emit;
  logic                   w_final_weight;
  logic                   w_last_lane;
  logic [L7_WEIGHT_W-1:0] w_lane_data;

  assign w_emit         = (r_state == EMIT);
  assign w_final_weight = (w_count == 16'(WEIGHT_NUM - 1));
  assign w_last_lane    = (r_lane == 1'(LANES - 1)) || w_final_weight;
  assign w_hs           = w_ready & i_in_valid;
  assign w_lane_data    = lane_select(r_buf, r_lane);

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = RECV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RECV: begin
        w_ready = 1'b1;
        if (i_in_valid) begin
          w_state_nxt = EMIT;
        end else begin
          w_state_nxt = RECV;
        end
      end
      EMIT: begin
        if (w_last_lane) begin
          // Overlap the next beat with the final lane, except after the very last weight.
          if (w_final_weight) begin
            w_ready     = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_ready = 1'b1;
            if (i_in_valid) begin
              w_state_nxt = EMIT;
            end else begin
              w_state_nxt = RECV;
            end
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat buffer and lane pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_lane <= 1'b0;
    end else if (w_hs) begin
      r_buf  <= i_in_data;
      r_lane <= 1'b0;
    end else if (w_emit) begin
      r_lane <= r_lane + 1'b1;
    end else begin
      r_lane <= r_lane;
    end
  end

  // Load status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_loaded <= 1'b0;
    end else if (w_start_acc) begin
      r_busy   <= 1'b1;
      r_loaded <= 1'b0;
    end else if (r_state == DONE) begin
      r_busy   <= 1'b0;
      r_loaded <= 1'b1;
    end else begin
      r_busy   <= r_busy;
      r_loaded <= r_loaded;
    end
  end

  counter_cnn #(
    .W(16)
  ) u_index_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_acc),
    .i_en    (w_emit),
    .o_count (w_count)
  );

`ifdef LAYER7_WLOAD_CKSUM_EN
  logic [15:0] r_cksum;

  // Running modulo-2^16 sum of written weights; frozen between done and the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cksum <= 16'd0;
    end else if (w_start_acc) begin
      r_cksum <= 16'd0;
    end else if (w_emit) begin
      r_cksum <= r_cksum + w_lane_data;
    end else begin
      r_cksum <= r_cksum;
    end
  end

  assign o_cksum = r_cksum;
`endif

  assign o_in_ready            = w_ready;
  assign o_write_weight_signal = w_emit;
  assign o_write_weight_data   = w_emit ? w_lane_data : 16'd0;
  assign o_write_weight_addr   = w_emit ? w_count : 16'd0;
  assign o_busy                = r_busy;
  assign o_done                = (r_state == DONE);
  assign o_weights_loaded      = r_loaded;

endmodule

// File: tb/tb_layer7_weight_loader.sv
// Scoreboard bench for layer7_weight_loader: the driver queues expected writes at each
// handshake, a negedge monitor pops and compares every write the DUT presents.
module tb_layer7_weight_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_in_valid;
  logic [31:0] i_in_data;
  logic        o_in_ready;
  logic        o_write_weight_signal;
  logic [15:0] o_write_weight_data;
  logic [15:0] o_write_weight_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_weights_loaded;
`ifdef LAYER7_WLOAD_CKSUM_EN
  logic [15:0] o_cksum;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_wr_cyc = 0;
  int   first_wr_cyc = 0;
  wr_t  exp_q[$];
  logic [15:0] exp_sum;

  layer7_weight_loader dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_start               (i_start),
    .i_in_valid            (i_in_valid),
    .i_in_data             (i_in_data),
    .o_in_ready            (o_in_ready),
    .o_write_weight_signal (o_write_weight_signal),
    .o_write_weight_data   (o_write_weight_data),
    .o_write_weight_addr   (o_write_weight_addr),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_weights_loaded      (o_weights_loaded)
`ifdef LAYER7_WLOAD_CKSUM_EN
    ,
    .o_cksum               (o_cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && o_write_weight_signal) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'd0, o_write_weight_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, o_write_weight_addr}, {16'd0, e.addr});
        check("wr_data", {16'd0, o_write_weight_data}, {16'd0, e.data});
      end
      check("ready_in_emit", {31'd0, o_in_ready},
            {31'd0, (o_write_weight_addr[0] && o_write_weight_addr != 16'd399)});
      if (o_write_weight_addr[0]) begin
        check("no_bubble", cyc - last_wr_cyc, 32'd1);
      end
      if (o_write_weight_addr == 16'd0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  {31'd0, o_in_ready}, 32'd0);
    check({tag, "_wsig"},   {31'd0, o_write_weight_signal}, 32'd0);
    check({tag, "_wdata"},  {16'd0, o_write_weight_data}, 32'd0);
    check({tag, "_waddr"},  {16'd0, o_write_weight_addr}, 32'd0);
    check({tag, "_busy"},   {31'd0, o_busy}, 32'd0);
    check({tag, "_done"},   {31'd0, o_done}, 32'd0);
    check({tag, "_loaded"}, {31'd0, o_weights_loaded}, 32'd0);
`ifdef LAYER7_WLOAD_CKSUM_EN
    check({tag, "_cksum"},  {16'd0, o_cksum}, 32'd0);
`endif
  endtask

  // mode 0: in_valid held; mode 1: in_valid 1,0,0 per beat. abort_at >= 0 resets at that address.
  task automatic run_load(input int mode, input bit poke_start, input int abort_at);
    int k, idle, guard, hs0;
    logic [15:0] lo, hi;
    wr_t e;
    k = 0; idle = 0; guard = 0; hs0 = -1;
    exp_sum = 16'd0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    check("loaded_cleared", {31'd0, o_weights_loaded}, 32'd0);
    while (k < 200 && guard < 3000) begin
      if (abort_at >= 0 && o_write_weight_signal && o_write_weight_addr == 16'(abort_at)) begin
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        i_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (mode == 0) i_in_valid = 1'b1;
      else i_in_valid = (idle == 0);
      lo = 16'(2 * k);
      hi = 16'(2 * k + 1);
      i_in_data = {hi, lo};
      i_start = (poke_start && k >= 50 && k < 52);
      if (i_in_valid && o_in_ready) begin
        if (hs0 < 0) hs0 = cyc;
        e.addr = lo; e.data = lo; exp_q.push_back(e);
        e.addr = hi; e.data = hi; exp_q.push_back(e);
        exp_sum = exp_sum + lo + hi;
        k++;
        idle = 2;
      end else if (idle > 0) begin
        idle--;
      end
      @(negedge clk);
      guard++;
    end
    i_start = 1'b0;
    check("beats_accepted", k, 32'd200);
    check("busy_mid", {31'd0, o_busy}, 32'd1);
    // Offer an extra beat that must not be consumed.
    i_in_valid = 1'b1;
    i_in_data  = 32'hBEEF_DEAD;
    guard = 0;
    while (!o_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", {31'd0, o_done}, 32'd1);
    check("done_after_last", cyc - last_wr_cyc, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
    if (mode == 0) begin
      check("first_wr_latency", first_wr_cyc - hs0, 32'd1);
      check("total_cycles", cyc - hs0, 32'd401);
    end
`ifdef LAYER7_WLOAD_CKSUM_EN
    check("cksum_at_done", {16'd0, o_cksum}, {16'd0, exp_sum});
`endif
    @(negedge clk);
    check("done_pulse", {31'd0, o_done}, 32'd0);
    check("loaded_set", {31'd0, o_weights_loaded}, 32'd1);
    check("busy_cleared", {31'd0, o_busy}, 32'd0);
    check("idle_not_ready", {31'd0, o_in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("extra_beat_ignored", {31'd0, o_in_ready}, 32'd0);
    i_in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = 32'd0;
    exp_sum    = 16'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, o_in_ready}, 32'd0);
      check("idle_nowrite", {31'd0, o_write_weight_signal}, 32'd0);
    end
    run_load(0, 1'b0, -1);
    run_load(1, 1'b1, -1);
    run_load(0, 1'b0, 123);
    run_load(0, 1'b0, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
